// File: rtl/instr_issuer.sv
// instr_issuer: FIFO-buffered instruction register driving the controller start/waiting handshake.
// Define ISSUER_WATCHDOG_EN to add the EXEC watchdog (TIMEOUT parameter, sticky timeout_err).
module instr_issuer #(
    parameter int DEPTH = 4
`ifdef ISSUER_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [15:0]            in_instr,
    output logic                   in_ready,
    input  logic                   waiting,
    output logic                   start,
    output logic [2:0]             opcode,
    output logic [1:0]             ALU_op,
    output logic [1:0]             shift_op,
    output logic [2:0]             rn,
    output logic [2:0]             rd,
    output logic [2:0]             rm,
    output logic [15:0]            sximm8,
    output logic [15:0]            sximm5,
    output logic                   busy,
    output logic                   retired,
    output logic [$clog2(DEPTH):0] count,
    output logic                   timeout_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [15:0]   ir_q, ir_d;
    logic          seen_low_q, seen_low_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          retired_q, retired_d;
    logic          push_s, pop_s;

`ifdef ISSUER_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;
`endif

    assign push_s = in_valid && in_ready;

    // Handshake FSM: pop into IR, strobe start, wait for the controller to leave and re-enter waiting.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        seen_low_d = seen_low_q;
        retired_d  = 1'b0;
        pop_s      = 1'b0;
`ifdef ISSUER_WATCHDOG_EN
        wd_d       = wd_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((count_q != CW'(0)) && waiting) begin
                    pop_s   = 1'b1;
                    ir_d    = mem_q[rd_ptr_q];
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                seen_low_d = 1'b0;
                state_d    = S_EXEC;
`ifdef ISSUER_WATCHDOG_EN
                wd_d       = WW'(0);
`endif
            end
            S_EXEC: begin
                if (!waiting) begin
                    seen_low_d = 1'b1;
`ifdef ISSUER_WATCHDOG_EN
                    if (wd_q == WW'(TIMEOUT - 1)) begin
                        timeout_d  = 1'b1;
                        seen_low_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        wd_d = wd_q + WW'(1);
                    end
`endif
                end else if (!seen_low_q) begin
                    // Controller never left waiting: it missed the strobe, so re-issue.
                    state_d = S_ISSUE;
                end else begin
                    retired_d  = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        start_d = (state_d == S_ISSUE);
        busy_d  = (state_d != S_IDLE);
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; occupancy is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= PW'(0);
            rd_ptr_q   <= PW'(0);
            count_q    <= CW'(0);
            state_q    <= S_IDLE;
            ir_q       <= 16'h0000;
            seen_low_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            retired_q  <= 1'b0;
`ifdef ISSUER_WATCHDOG_EN
            wd_q       <= WW'(0);
            timeout_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            ir_q       <= ir_d;
            seen_low_q <= seen_low_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            retired_q  <= retired_d;
`ifdef ISSUER_WATCHDOG_EN
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign in_ready = (count_q != FULL);
    assign count    = count_q;
    assign start    = start_q;
    assign busy     = busy_q;
    assign retired  = retired_q;
    assign opcode   = ir_q[15:13];
    assign ALU_op   = ir_q[12:11];
    assign rn       = ir_q[10:8];
    assign rd       = ir_q[7:5];
    assign shift_op = ir_q[4:3];
    assign rm       = ir_q[2:0];
    assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};
`ifdef ISSUER_WATCHDOG_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed handshake scenarios plus a randomized
// push/latency run checked against a queue-based reference of the issue order.
module tb_instr_issuer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        waiting;
    logic        in_ready, start, busy, retired, timeout_err;
    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  ALU_op, shift_op;
    logic [15:0] sximm8, sximm5;
    logic [2:0]  count;

    int tests  = 0;
    int failed = 0;
    int mcount = 0;
    int prev_mcount = 0;
    bit rand_push = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] pend[$];

    instr_issuer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .waiting(waiting), .start(start), .opcode(opcode),
        .ALU_op(ALU_op), .shift_op(shift_op), .rn(rn), .rd(rd), .rm(rm),
        .sximm8(sximm8), .sximm5(sximm5), .busy(busy), .retired(retired),
        .count(count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    wire [47:0] fields_w = {opcode, ALU_op, rn, rd, shift_op, rm, sximm8, sximm5};

    function automatic logic [47:0] decode(input logic [15:0] i);
        logic [15:0] s8, s5;
        s8 = 16'(signed'(i[7:0]));
        s5 = 16'(signed'(i[4:0]));
        return {i[15:13], i[12:11], i[10:8], i[7:5], i[4:3], i[2:0], s8, s5};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive a push request, check in_ready against the model, then update the model.
    task automatic step(input logic vld, input logic [15:0] d, output bit acc);
        in_valid = vld;
        in_instr = d;
        check("in_ready", in_ready, (mcount < DEPTH));
        acc = vld && (mcount < DEPTH);
        prev_mcount = mcount;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_q.push_back(d);
            mcount++;
        end
        in_valid = 1'b0;
    endtask

    task automatic rstep();
        bit acc;
        if (rand_push && pend.size() > 0 && $urandom_range(0, 2) != 0) begin
            step(1'b1, pend[0], acc);
            if (acc) void'(pend.pop_front());
        end else begin
            step(1'b0, 16'($urandom), acc);
        end
    endtask

    // Controller model: accept the strobe, hold waiting low for lat cycles, then return to waiting.
    task automatic run_one(input int lat);
        int n;
        logic [15:0] ex;
        logic [47:0] f;
        n = 0;
        waiting = 1'b1;
        while (start !== 1'b1 && n < 60) begin
            rstep();
            n++;
        end
        check("start_seen", start, 1'b1);
        if (start === 1'b1) begin
            mcount--;
            ex = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            f = decode(ex);
            check("issue_fields", fields_w, f);
            check("issue_count", count, mcount);
            check("issue_busy", busy, 1'b1);
            rstep();
            check("start_one_cycle", start, 1'b0);
            check("exec_busy", busy, 1'b1);
            waiting = 1'b0;
            repeat (lat) begin
                rstep();
                check("hold_fields", fields_w, f);
                check("no_early_retire", retired, 1'b0);
                check("no_restart", start, 1'b0);
            end
            waiting = 1'b1;
            rstep();
            check("retired_pulse", retired, 1'b1);
            check("retire_idle", busy, 1'b0);
            check("retire_fields", fields_w, f);
            rstep();
            check("retired_once", retired, 1'b0);
            check("next_issue", start, (prev_mcount > 0));
        end
    endtask

    initial begin
        bit acc;
        int n;
        logic [15:0] ex;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        waiting = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_retired", retired, 1'b0);
        check("rst_fields", fields_w, 48'h0);
        check("rst_timeout", timeout_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MOV immediate, no bypass into IR
        step(1'b1, 16'hD107, acc);
        check("push_count", count, 3'd1);
        check("no_bypass", start, 1'b0);
        run_one(1);
        check("mov_opcode", opcode, 3'b110);
        check("mov_sximm8", sximm8, 16'h0007);
        check("mov_drained", count, 3'd0);

        // ADD with a 4-cycle controller
        step(1'b1, 16'hA143, acc);
        run_one(4);
        check("add_rd", rd, 3'd2);

        // Fill while the controller is busy; fifth push is dropped
        waiting = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'($urandom), acc);
            check("fill_count", count, (i < DEPTH) ? i + 1 : DEPTH);
        end
        check("full_in_ready", in_ready, 1'b0);
        repeat (4) run_one($urandom_range(1, 3));
        check("full_drained", count, 3'd0);

        // Rejected strobe: waiting never drops, so start is re-asserted
        waiting = 1'b0;
        step(1'b1, 16'h6A5C, acc);
        waiting = 1'b1;
        rstep();
        check("rs_start1", start, 1'b1);
        mcount--;
        ex = exp_q.pop_front();
        rstep();
        check("rs_exec", start, 1'b0);
        rstep();
        check("rs_restart", start, 1'b1);
        check("rs_fields", fields_w, decode(ex));
        rstep();
        waiting = 1'b0;
        rstep();
        waiting = 1'b1;
        rstep();
        check("rs_retired", retired, 1'b1);
        rstep();
        check("rs_retired_once", retired, 1'b0);

`ifdef ISSUER_WATCHDOG_EN
        step(1'b1, 16'h4321, acc);
        rstep();
        check("wd_start", start, 1'b1);
        mcount--;
        void'(exp_q.pop_front());
        rstep();
        waiting = 1'b0;
        repeat (14) begin
            rstep();
            check("wd_busy", busy, 1'b1);
            check("wd_not_yet", timeout_err, 1'b0);
        end
        rstep();
        check("wd_fired", timeout_err, 1'b1);
        check("wd_idle", busy, 1'b0);
        check("wd_no_retire", retired, 1'b0);
        rstep();
        check("wd_sticky", timeout_err, 1'b1);
        check("wd_no_retire2", retired, 1'b0);
        waiting = 1'b1;
`else
        step(1'b1, 16'h4321, acc);
        run_one(30);
        check("no_watchdog", timeout_err, 1'b0);
`endif

        // Async reset in the middle of EXEC with the FIFO partly full
        waiting = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), acc);
        waiting = 1'b1;
        rstep();
        mcount--;
        rstep();
        waiting = 1'b0;
        rstep();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_start", start, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_count", count, 3'd0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_retired", retired, 1'b0);
        check("arst_fields", fields_w, 48'h0);
        check("arst_timeout", timeout_err, 1'b0);
        mcount = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        waiting = 1'b1;
        repeat (3) begin
            rstep();
            check("arst_discard", start, 1'b0);
            check("arst_no_retire", retired, 1'b0);
        end

        // Randomized pushes against a random-latency controller
        rand_push = 1'b1;
        for (int i = 0; i < 30; i++) pend.push_back(16'($urandom));
        n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0 || mcount > 0) && n < 40) begin
            run_one($urandom_range(1, 5));
            n++;
        end
        check("rand_all_issued", pend.size() + exp_q.size(), 0);
        check("rand_drained", count, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
